// File: rtl/adc_conv_scheduler.sv
// Round-robin scheduler sharing one SAR ADC among N_REQ requesters:
// arbitrates, drives the sample/convert strobe, waits for done or timeout, delivers the result.
module adc_conv_scheduler #(
    parameter int N_REQ       = 4,
    parameter int SAMPLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int RES_W       = 12,
    localparam int SEL_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] adc_sel,
    output logic             st_conv,
    input  logic             adc_done,
    input  logic [RES_W-1:0] adc_result,
    output logic             res_valid,
    output logic [RES_W-1:0] res_data,
    output logic [SEL_W-1:0] res_id,
    output logic             res_err,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONV    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             conv_err, conv_err_nxt;
    logic [SEL_W-1:0] rr_ptr;

    // adc_done is asynchronous: two flops for metastability, a third for edge detect.
    logic done_s1, done_s2, done_s3;
    logic done_edge;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_s3 <= 1'b0;
        end else begin
            done_s1 <= adc_done;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
        end
    end

    assign done_edge = done_s2 & ~done_s3;

    // Round-robin: rotate req so bit 0 is the requester at rr_ptr, take the lowest set bit.
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]   win_off;
    logic [SEL_W:0]     win_sum;
    logic [SEL_W-1:0]   win_idx;
    logic               win_found;

    assign req_dbl   = {req, req};
    assign req_rot   = req_dbl[rr_ptr +: N_REQ];
    assign win_found = |req;

    always_comb begin
        win_off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) win_off = SEL_W'(j);
        end
    end

    assign win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    assign win_idx = (win_sum >= (SEL_W+1)'(N_REQ)) ?
                     SEL_W'(win_sum - (SEL_W+1)'(N_REQ)) : win_sum[SEL_W-1:0];

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            conv_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            conv_err <= conv_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        conv_err_nxt = conv_err;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (win_found) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (cnt == SAMPLE_LAST) begin
                    state_nxt = CONV;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CONV: begin
                // A done edge on the final counted cycle still beats the timeout.
                if (done_edge) begin
                    state_nxt    = CAPTURE;
                    conv_err_nxt = 1'b0;
                    cnt_nxt      = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt    = CAPTURE;
                    conv_err_nxt = 1'b1;
                    cnt_nxt      = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // res_valid is a single-cycle pulse with no backpressure: the consumer must take
    // res_data/res_id/res_err in that cycle; the values hold until the next pulse.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            adc_sel   <= '0;
            st_conv   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant   <= N_REQ'(1) << win_idx;
                        adc_sel <= win_idx;
                        st_conv <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt == SAMPLE_LAST) st_conv <= 1'b0;
                end
                CAPTURE: begin
                    if (!conv_err) res_data <= adc_result;
                    res_id    <= adc_sel;
                    res_err   <= conv_err;
                    res_valid <= 1'b1;
                    grant     <= '0;
                    rr_ptr    <= (adc_sel == SEL_W'(N_REQ - 1)) ? '0 : adc_sel + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Bench for adc_conv_scheduler: directed vector table, reset-mid-conversion sequence,
// then random conversions checked against a transaction-level model.
module tb_adc_conv_scheduler;

  localparam int N_REQ       = 4;
  localparam int SAMPLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int RES_W       = 12;
  localparam int SEL_W       = 2;

  logic             clkin;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] adc_sel;
  logic             st_conv;
  logic             adc_done;
  logic [RES_W-1:0] adc_result;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic [SEL_W-1:0] res_id;
  logic             res_err;
  logic             busy;
  logic [1:0]       dbg_state;

  adc_conv_scheduler #(
    .N_REQ(N_REQ), .SAMPLE_CYC(SAMPLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .RES_W(RES_W)
  ) dut (
    .clkin(clkin), .rst(rst), .req(req), .grant(grant), .adc_sel(adc_sel),
    .st_conv(st_conv), .adc_done(adc_done), .adc_result(adc_result),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_err(res_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_vec  = 0;
  int n_err  = 0;
  int vcount = 0;
  int n_conv = 0;

  always @(posedge clkin) if (res_valid === 1'b1) vcount++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    int          d;         // negedges after st_conv fall before adc_done rises
    logic [11:0] result;
    bit          drop;      // release req during SAMPLE
    bit          stale;     // spurious done pulse during SAMPLE
    int          exp_id;
    bit          exp_err;
    logic [11:0] exp_data;
    int          exp_lat;   // negedges from st_conv fall to res_valid
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input int d, input logic [11:0] res,
                              input bit drop, input bit stale, input int id, input bit err,
                              input logic [11:0] data, input int lat);
    vec_t v;
    v.req = r; v.d = d; v.result = res; v.drop = drop; v.stale = stale;
    v.exp_id = id; v.exp_err = err; v.exp_data = data; v.exp_lat = lat;
    return v;
  endfunction

  // reference model: round-robin pick plus transaction timing
  int          m_ptr;
  logic [11:0] m_data;

  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    int idx;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (ptr + k) % N_REQ;
      if (r[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  // done reaches the FSM two cycles after it is driven; capture and delivery add two more.
  function automatic vec_t model(input logic [3:0] r, input int d, input logic [11:0] res,
                                 input bit drop, input bit stale);
    vec_t v;
    bit   err;
    int   id;
    id  = rr_pick(r, m_ptr);
    err = (d + 2 > TIMEOUT_CYC - 1);
    v = mk(r, d, res, drop, stale, id, err, err ? m_data : res,
           err ? TIMEOUT_CYC + 1 : d + 4);
    m_ptr  = (id + 1) % N_REQ;
    m_data = v.exp_data;
    return v;
  endfunction

  // driver: one full conversion
  task automatic run_conv(input vec_t v);
    int wait_n, st_len, cnt;
    bit sel_ok;
    n_conv++;
    req = v.req;
    @(negedge clkin);
    wait_n = 1;
    while (st_conv !== 1'b1 && wait_n < 20) begin
      @(negedge clkin);
      wait_n++;
    end
    check("req_to_st_conv", wait_n, 1);
    check("grant", 32'(grant), 32'(1) << v.exp_id);
    check("adc_sel", 32'(adc_sel), v.exp_id);
    check("busy_sample", 32'(busy), 1);
    st_len = 0;
    sel_ok = 1'b1;
    while (st_conv === 1'b1 && st_len < 300) begin
      st_len++;
      if (v.stale && st_len == 1) begin adc_done = 1'b1; adc_result = 12'hBAD; end
      if (v.stale && st_len == 2) adc_done = 1'b0;
      if (v.drop && st_len == 1) req = '0;
      if (adc_sel !== v.exp_id[1:0]) sel_ok = 1'b0;
      @(negedge clkin);
    end
    check("st_conv_width", st_len, SAMPLE_CYC);
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 300) begin
      if (adc_sel !== v.exp_id[1:0]) sel_ok = 1'b0;
      if (cnt == v.d) begin adc_done = 1'b1; adc_result = v.result; end
      @(negedge clkin);
      cnt++;
    end
    check("res_valid_seen", 32'(res_valid), 1);
    check("latency", cnt, v.exp_lat);
    check("res_id", 32'(res_id), v.exp_id);
    check("res_err", 32'(res_err), 32'(v.exp_err));
    check("res_data", 32'(res_data), 32'(v.exp_data));
    check("busy_after", 32'(busy), 0);
    check("grant_after", 32'(grant), 0);
    check("adc_sel_stable", 32'(sel_ok), 1);
    adc_done = 1'b0;
  endtask

  vec_t tbl[19];
  vec_t rv;
  int   pre, k;

  initial begin
    rst = 1'b1; req = '0; adc_done = 1'b0; adc_result = '0;
    repeat (3) @(negedge clkin);
    check("rst_st_conv", 32'(st_conv), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_adc_sel", 32'(adc_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_id", 32'(res_id), 0);
    check("rst_res_err", 32'(res_err), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    @(negedge clkin);

    for (int i = 0; i < 8; i++)
      tbl[i] = mk(4'hF, 3, 12'(12'h100 + i), 0, 0, i % 4, 0, 12'(12'h100 + i), 7);
    tbl[8]  = mk(4'b0100, 10,  12'hA5C, 0, 0, 2, 0, 12'hA5C, 14);
    tbl[9]  = mk(4'b0001, 200, 12'h000, 0, 0, 0, 1, 12'hA5C, 65);
    tbl[10] = mk(4'b0001, 61,  12'h3C3, 0, 0, 0, 0, 12'h3C3, 65);
    tbl[11] = mk(4'b0001, 62,  12'h777, 0, 0, 0, 1, 12'h3C3, 65);
    tbl[12] = mk(4'b0010, 10,  12'h5A5, 0, 1, 1, 0, 12'h5A5, 14);
    tbl[13] = mk(4'b1000, 0,   12'h123, 1, 0, 3, 0, 12'h123, 4);
    tbl[14] = mk(4'b0011, 5,   12'h0F0, 0, 0, 0, 0, 12'h0F0, 9);
    tbl[15] = mk(4'b0011, 5,   12'h0F1, 0, 0, 1, 0, 12'h0F1, 9);
    tbl[16] = mk(4'b0011, 5,   12'h0F2, 0, 0, 0, 0, 12'h0F2, 9);
    tbl[17] = mk(4'b1010, 1,   12'hFFF, 0, 0, 1, 0, 12'hFFF, 5);
    tbl[18] = mk(4'b1010, 2,   12'h000, 0, 0, 3, 0, 12'h000, 6);
    for (int i = 0; i < 19; i++) run_conv(tbl[i]);
    req = '0;

    // reset three cycles into CONV
    req = 4'b0010;
    k = 0;
    @(negedge clkin);
    while (st_conv !== 1'b1 && k < 20) begin @(negedge clkin); k++; end
    while (st_conv === 1'b1 && k < 40) begin @(negedge clkin); k++; end
    check("mid_reset_reach_conv", 32'(k < 40), 1);
    repeat (3) @(negedge clkin);
    #2 rst = 1'b1;
    #1;
    pre = vcount;
    check("mrst_st_conv", 32'(st_conv), 0);
    check("mrst_grant", 32'(grant), 0);
    check("mrst_adc_sel", 32'(adc_sel), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_res_valid", 32'(res_valid), 0);
    check("mrst_res_data", 32'(res_data), 0);
    check("mrst_res_id", 32'(res_id), 0);
    req = '0;
    @(negedge clkin);
    rst = 1'b0;
    repeat (10) @(negedge clkin);
    check("mrst_no_valid", vcount, pre);
    run_conv(mk(4'b1010, 4, 12'h456, 0, 0, 1, 0, 12'h456, 8));

    m_ptr  = 2;
    m_data = 12'h456;
    for (int i = 0; i < 25; i++) begin
      int d;
      if ($urandom_range(0, 7) == 0) d = $urandom_range(58, 70);
      else d = $urandom_range(0, 20);
      rv = model(4'($urandom_range(1, 15)), d, 12'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      run_conv(rv);
    end
    req = '0;
    repeat (5) @(negedge clkin);
    check("res_valid_count", vcount, n_conv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_conv_scheduler.md
ADC_CONV_SCHEDULER -- requirements
Module: adc_conv_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the SAR ADC (2..8).
REQ-002 Parameter SAMPLE_CYC, default 4, clkin cycles st_conv is held high (1..255).
REQ-003 Parameter TIMEOUT_CYC, default 64, max clkin cycles from st_conv fall to done (1..1023).
REQ-004 Parameter RES_W, default 12, ADC result width.
REQ-005 clkin  input  1  block clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  N_REQ  level conversion request, one bit per requester.
REQ-008 grant  output  N_REQ  one-hot owner of current conversion; zero when idle.
REQ-009 adc_sel  output  clog2(N_REQ)  analog input mux select, index of granted requester.
REQ-010 st_conv  output  1  to ADC: high = sample, falling edge = start conversion.
REQ-011 adc_done  input  1  from ADC, asynchronous to clkin; high = conversion finished.
REQ-012 adc_result  input  RES_W  ADC final result; stable while adc_done high.
REQ-013 res_valid  output  1  one-cycle pulse, result delivered.
REQ-014 res_data  output  RES_W  captured result; held until next res_valid.
REQ-015 res_id  output  clog2(N_REQ)  requester index of res_data.
REQ-016 res_err  output  1  qualified by res_valid; 1 = conversion timed out.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SAMPLE, CONV, CAPTURE.
REQ-019 adc_done SHALL pass a 2-flop synchronizer; done_edge = rising edge of synchronized signal.
REQ-020 IDLE: if req!=0, select winner by round-robin from pointer rr_ptr (first set bit at index >= rr_ptr, wrapping), register grant/adc_sel, go to SAMPLE next cycle.
REQ-021 IDLE with req==0: remain, grant=0, st_conv=0.
REQ-022 SAMPLE: st_conv=1 for exactly SAMPLE_CYC cycles, first high cycle is first SAMPLE cycle; then go to CONV with st_conv=0.
REQ-023 adc_sel SHALL be stable from first SAMPLE cycle through CAPTURE.
REQ-024 CONV: count cycles from entry; on done_edge go to CAPTURE with error=0; if count reaches TIMEOUT_CYC without done_edge go to CAPTURE with error=1.
REQ-025 done_edge and timeout in the same cycle: done wins, error=0.
REQ-026 done_edge seen in IDLE or SAMPLE SHALL be ignored (stale done from previous conversion).
REQ-027 CAPTURE (one cycle): res_data<=adc_result (unchanged if error), res_id<=grant index, res_err<=error, res_valid=1 on the following cycle, grant cleared, rr_ptr<=(grant index+1) mod N_REQ, return to IDLE.
REQ-028 Minimum request-to-st_conv latency: 1 cycle (req sampled in IDLE, st_conv high next cycle).
REQ-029 Deassertion of the granted req bit mid-conversion SHALL NOT abort; conversion completes and result is delivered.
REQ-030 A requester whose req stays high after res_valid is treated as a new request and arbitrated behind others via rr_ptr.
REQ-031 Only one conversion outstanding; requests during busy are held by requesters, not queued.

Reset
REQ-032 On rst: state=IDLE, grant=0, adc_sel=0, st_conv=0, res_valid=0, res_data=0, res_id=0, res_err=0, busy=0, rr_ptr=0, counters=0, synchronizer flops=0.
REQ-033 rst mid-conversion SHALL abandon it without res_valid; st_conv low immediately (asynchronous).
REQ-034 First arbitration after reset starts from index 0.

Verification
REQ-035 Single: req=4'b0100, ADC returns 0xA5C 10 cycles after st_conv fall -> st_conv high 4 cycles, adc_sel=2, res_valid once, res_data=0xA5C, res_id=2, res_err=0.
REQ-036 Fairness: req=4'b1111 held for 8 conversions -> res_id sequence 0,1,2,3,0,1,2,3.
REQ-037 Timeout: req=4'b0001, adc_done never rises -> res_valid after 64 CONV cycles, res_err=1, res_id=0, busy drops next cycle.
REQ-038 Stale done: adc_done held high from previous conversion into SAMPLE, falls, rises in CONV -> exactly one capture, on the new rise only.
REQ-039 Reset mid-CONV: req=4'b0010, rst pulsed 3 cycles into CONV -> no res_valid, all outputs at reset values, next req=4'b1010 grants index 1 first.
REQ-040 Simultaneous done and timeout at cycle 64 -> res_err=0, res_data=adc_result.
